// File: rtl/ped_walk_countdown_pkg.sv
// Shared types and helpers for the pedestrian walk countdown block.
package ped_walk_pkg;

    // Crossing phases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        CLEAR = 2'd2
    } ped_state_t;

    // One BCD display digit
    typedef logic [3:0] bcd_digit_t;

    // Two-digit BCD display value
    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd2_t;

    // Legal parameter ranges
    localparam int unsigned MAX_PHASE_SECS    = 99;
    localparam int unsigned MIN_TICKS_PER_SEC = 2;

    // Decrement a two-digit BCD value in place; ones borrow from tens (10 -> 09).
    // Callers never decrement 00, so no underflow handling is needed.
    function automatic bcd2_t bcd2_dec(input bcd_digit_t tens, input bcd_digit_t ones);
        bcd2_t r;
        if (ones == 4'd0) begin
            r.ones = 4'd9;
            r.tens = tens - 4'd1;
        end else begin
            r.ones = ones - 4'd1;
            r.tens = tens;
        end
        return r;
    endfunction

endpackage

// File: rtl/ped_walk_countdown_sec_prescaler.sv
// Free-running seconds prescaler with synchronous clear.
// sec_tick marks the last cycle of each second; half_tick marks the last
// cycle of each half second (it also fires with sec_tick).
module sec_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic sec_tick,
    output logic half_tick
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(TICKS_PER_SEC / 2 - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Count 0..TICKS_PER_SEC-1, restarting from zero on clear or wrap
    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (clear || (cnt_reg == LAST_CNT)) begin
            cnt_next = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign sec_tick  = (cnt_reg == LAST_CNT);
    assign half_tick = (cnt_reg == HALF_CNT) || sec_tick;

endmodule

// File: rtl/ped_walk_countdown.sv
// Pedestrian crossing timer: latches walk requests, runs a timed WALK phase
// and a flashing CLEAR phase after a controller grant, and drives a
// two-digit BCD countdown. All outputs come straight from registers.
module ped_walk_countdown
    import ped_walk_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned WALK_SECS     = 4,
    parameter int unsigned CLEAR_SECS    = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       walk_req,
    input  logic       walk_go,
    output logic       ped_pending,
    output logic       walk_on,
    output logic       dont_walk,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       blank,
    output logic       done
);

    // Refuse to elaborate with parameters the display or flasher cannot honour
    if (WALK_SECS > MAX_PHASE_SECS) begin : g_bad_walk_secs
        $error("ped_walk_countdown: WALK_SECS must be 0..99");
    end
    if (CLEAR_SECS > MAX_PHASE_SECS) begin : g_bad_clear_secs
        $error("ped_walk_countdown: CLEAR_SECS must be 0..99");
    end
    if ((TICKS_PER_SEC < MIN_TICKS_PER_SEC) || (TICKS_PER_SEC % 2 != 0)) begin : g_bad_ticks
        $error("ped_walk_countdown: TICKS_PER_SEC must be even and >= 2");
    end

    localparam bcd_digit_t WALK_TENS  = bcd_digit_t'(WALK_SECS / 10);
    localparam bcd_digit_t WALK_ONES  = bcd_digit_t'(WALK_SECS % 10);
    localparam bcd_digit_t CLEAR_TENS = bcd_digit_t'(CLEAR_SECS / 10);
    localparam bcd_digit_t CLEAR_ONES = bcd_digit_t'(CLEAR_SECS % 10);

    ped_state_t state_reg, state_next;
    logic       pending_reg, pending_next;
    logic       walk_on_reg, walk_on_next;
    logic       dont_walk_reg, dont_walk_next;
    bcd_digit_t tens_reg, tens_next;
    bcd_digit_t ones_reg, ones_next;
    logic       blank_reg, blank_next;
    logic       done_reg, done_next;
    logic       phase_entry;
    logic       sec_tick;
    logic       half_tick;
    logic       at_zero;
    bcd2_t      dec_val;

    // Prescaler is held at zero in IDLE and restarted on every phase change,
    // so each phase begins on a fresh second boundary.
    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (phase_entry || (state_reg == IDLE)),
        .sec_tick (sec_tick),
        .half_tick(half_tick)
    );

    assign at_zero = (tens_reg == 4'd0) && (ones_reg == 4'd0);

    // Next-state, request latch and display update
    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg | walk_req;
        walk_on_next   = walk_on_reg;
        dont_walk_next = dont_walk_reg;
        tens_next      = tens_reg;
        ones_next      = ones_reg;
        blank_next     = blank_reg;
        done_next      = 1'b0;
        phase_entry    = 1'b0;
        dec_val        = bcd2_dec(tens_reg, ones_reg);

        case (state_reg)
            IDLE: begin
                // A grant only counts when a request is waiting; a request in
                // the same cycle stays latched for the following crossing.
                if (walk_go && pending_reg) begin
                    state_next     = WALK;
                    pending_next   = walk_req;
                    walk_on_next   = 1'b1;
                    dont_walk_next = 1'b0;
                    blank_next     = 1'b0;
                    tens_next      = WALK_TENS;
                    ones_next      = WALK_ONES;
                    phase_entry    = 1'b1;
                end
            end
            WALK: begin
                if (sec_tick) begin
                    if (at_zero) begin
                        state_next     = CLEAR;
                        walk_on_next   = 1'b0;
                        dont_walk_next = 1'b1;
                        tens_next      = CLEAR_TENS;
                        ones_next      = CLEAR_ONES;
                        phase_entry    = 1'b1;
                    end else begin
                        tens_next = dec_val.tens;
                        ones_next = dec_val.ones;
                    end
                end
            end
            CLEAR: begin
                if (half_tick) begin
                    dont_walk_next = ~dont_walk_reg;
                end
                if (sec_tick) begin
                    if (at_zero) begin
                        state_next     = IDLE;
                        dont_walk_next = 1'b1;
                        blank_next     = 1'b1;
                        tens_next      = 4'd0;
                        ones_next      = 4'd0;
                        done_next      = 1'b1;
                        phase_entry    = 1'b1;
                    end else begin
                        tens_next = dec_val.tens;
                        ones_next = dec_val.ones;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            pending_reg   <= 1'b0;
            walk_on_reg   <= 1'b0;
            dont_walk_reg <= 1'b1;
            tens_reg      <= 4'd0;
            ones_reg      <= 4'd0;
            blank_reg     <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            walk_on_reg   <= walk_on_next;
            dont_walk_reg <= dont_walk_next;
            tens_reg      <= tens_next;
            ones_reg      <= ones_next;
            blank_reg     <= blank_next;
            done_reg      <= done_next;
        end
    end

    assign ped_pending = pending_reg;
    assign walk_on     = walk_on_reg;
    assign dont_walk   = dont_walk_reg;
    assign bcd_tens    = tens_reg;
    assign bcd_ones    = ones_reg;
    assign blank       = blank_reg;
    assign done        = done_reg;

endmodule

// File: doc/ped_walk_countdown.md
# ped_walk_countdown

Parametrised pedestrian crossing timer for the traffic light controller. It latches a walk-button request and waits for the intersection controller to grant the crossing. It then runs a timed WALK phase and a flashing CLEAR (don't-walk) phase. Throughout both phases it drives a two-digit BCD countdown to the crosswalk display. It replaces the fixed single-digit, externally-timed countdown decoder with a self-timed, configurable block.

## Interface
- TICKS_PER_SEC, default 100_000_000: clock cycles per second. Must be even and ≥ 2.
- WALK_SECS, default 4: WALK phase display start value, 0–99.
- CLEAR_SECS, default 9: CLEAR phase display start value, 0–99.

- clk  in  1  system clock, single domain
- reset_n  in  1  asynchronous, active-low reset
- walk_req  in  1  button request, level or pulse, sampled every cycle
- walk_go  in  1  controller grant, single-cycle pulse
- ped_pending  out  1  request latched and awaiting grant
- walk_on  out  1  WALK lamp
- dont_walk  out  1  DON'T WALK lamp (steady or flashing)
- bcd_tens  out  4  countdown tens digit
- bcd_ones  out  4  countdown ones digit
- blank  out  1  display blanked (IDLE)
- done  out  1  one-cycle pulse on return to IDLE

## Operation
- States: IDLE, WALK, CLEAR.
- Reset values: state=IDLE, ped_pending=0, walk_on=0, dont_walk=1, bcd_tens=0, bcd_ones=0, blank=1, done=0, prescaler=0.
- Request latch:
  - walk_req=1 in any state sets ped_pending.
  - ped_pending clears only when a grant is accepted.
- IDLE → WALK:
  - Taken when walk_go=1 and ped_pending=1.
  - walk_go without ped_pending is ignored.
  - walk_go outside IDLE is ignored.
- WALK:
  - walk_on=1, dont_walk=0, blank=0.
  - Display loads WALK_SECS and decrements by 1 on each second tick.
  - A second tick occurring while the display reads 00 moves the block to CLEAR.
- CLEAR:
  - walk_on=0, blank=0.
  - Display loads CLEAR_SECS. Same countdown rule as WALK.
  - dont_walk starts at 1 on entry and toggles every TICKS_PER_SEC/2 cycles.
  - A tick at 00 moves the block to IDLE.
- Return to IDLE: dont_walk=1, blank=1, digits=0, done=1 for exactly that first IDLE cycle.
- Arithmetic: the display is held in BCD and decremented directly. When ones=0, ones wraps to 9 and tens decrements (e.g. 10 → 09). No binary-to-BCD conversion.
- Simultaneous events:
  - walk_req in the same cycle as the grant: ped_pending stays 1, queuing the next crossing.
  - walk_req in the same cycle as done: ped_pending is set.
- Parameters out of range (WALK_SECS or CLEAR_SECS > 99, odd TICKS_PER_SEC) stop elaboration via a static assertion.

## Timing
- All outputs are registered.
- Grant accepted at edge N: walk_on=1 and the display shows WALK_SECS from cycle N+1.
- Prescaler:
  - Width is $clog2(TICKS_PER_SEC).
  - Cleared on every phase entry.
  - A second tick is the cycle in which the prescaler equals TICKS_PER_SEC−1.
- Phase durations: WALK lasts exactly (WALK_SECS+1)×TICKS_PER_SEC cycles; CLEAR lasts (CLEAR_SECS+1)×TICKS_PER_SEC cycles.
- Display change: digits update on the edge after a tick; each displayed value is held exactly TICKS_PER_SEC cycles.
- The next grant may be accepted in the done cycle. Minimum gap between crossings is 1 IDLE cycle.
- Reset asserted mid-phase forces the reset values immediately (asynchronously) and discards ped_pending.

## Structure
- Package ped_walk_pkg:
  - state enum (IDLE, WALK, CLEAR)
  - BCD digit typedef (4 bits)
  - bcd2_dec function (two-digit BCD decrement)
  - parameter-range check constants
- Sub-module sec_prescaler:
  - Parameter TICKS_PER_SEC.
  - Inputs: clk, reset_n, clear.
  - Outputs: sec_tick, half_tick.
  - Used for both the countdown and the flash toggle.
- FSM, request latch and display registers live in the top module.

## Test plan
Benches use TICKS_PER_SEC=10, WALK_SECS=4, CLEAR_SECS=12.
- Basic crossing: walk_req pulse, then walk_go 5 cycles later. Display reads 04,03,02,01,00, each for 10 cycles, with walk_on=1 for 50 cycles. CLEAR then reads 12…00 for 130 cycles, with dont_walk toggling every 5 cycles and starting at 1. done pulses once and blank returns to 1.
- Grant without request: walk_go with ped_pending=0 → state stays IDLE, all outputs unchanged.
- Queued request: walk_req during WALK → ped_pending=1 through CLEAR. A walk_go in the done cycle starts a new WALK on the next cycle with display 04.
- BCD borrow: in CLEAR, the display goes 10 → 09 → … → 00. Tens/ones are never invalid (ones never exceeds 9).
- Reset mid-CLEAR: reset_n low asynchronously, between clock edges, while display=07 → outputs take the reset values before the next edge. After release, walk_go is ignored until a new walk_req.
- Simultaneous walk_req and grant: ped_pending remains 1 throughout the crossing.
